pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 176 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one-entry-deep valid/ready pipeline stage with optional skid.
// The main register always drives the outputs; when the skid is built in, a
// second register catches the entry that arrives on the cycle the downstream
// stalls, so in_ready can come straight from a flop.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> skid register + FULL state, registered in_ready
//                       undefined -> single register, in_ready = !out_valid || out_ready
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   flush      synchronous discard of all held entries (beats accept/drain)
//   in_valid   upstream entry present
//   in_ready   stage can accept an entry this cycle
//   in_data    upstream data payload  [DATA_W]
//   in_ctrl    upstream control payload [CTRL_W]
//   out_valid  downstream entry present
//   out_ready  downstream accepts this cycle
//   out_data   downstream data payload (zero when out_valid is low)
//   out_ctrl   downstream control payload (NOP/zero when out_valid is low)
//   occupancy  entries held, 0..2
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // State encoding equals the number of entries held.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1
`ifdef PIPE_STAGE_SKID_EN
        ,
        S_FULL  = 2'd2
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;
`else
    // Holds in_ready low while in reset and until the first edge after release.
    logic              rdy_q;
`endif

    logic accept;
    logic drain;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b0;
`else
            rdy_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
`else
            rdy_q       <= 1'b1;
`endif
        end
    end

    // Next-state and register-load logic; registers are zeroed whenever they
    // are vacated so a stale payload never leaks onto the outputs.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
`endif
        if (flush) begin
            state_d     = S_EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_d = '0;
            skid_ctrl_d = '0;
`endif
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (accept && drain) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (accept) begin
                        // Downstream stalled: park the new entry behind main.
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = S_FULL;
`endif
                    end else if (drain) begin
                        main_data_d = '0;
                        main_ctrl_d = '0;
                        state_d     = S_EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                S_FULL: begin
                    if (drain) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_data_d = '0;
                        skid_ctrl_d = '0;
                        state_d     = S_BUSY;
                    end
                end
`endif
                default: begin
                    state_d     = S_EMPTY;
                    main_data_d = '0;
                    main_ctrl_d = '0;
                end
            endcase
        end
`ifdef PIPE_STAGE_SKID_EN
        in_ready_d = (state_d != S_FULL);
`endif
    end

    // Outputs decoded from registered state; payload gated to a NOP bubble.
    always_comb begin
        out_valid = (state_q != S_EMPTY);
        out_data  = out_valid ? main_data_q : '0;
        out_ctrl  = out_valid ? main_ctrl_q : '0;
        occupancy = 2'(state_q);
`ifdef PIPE_STAGE_SKID_EN
        in_ready  = in_ready_q;
`else
        in_ready  = rdy_q && (!out_valid || out_ready);
`endif
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vectors for pipe_stage_reg. The driver checks
// in_ready/out_valid/occupancy against hand-written values each cycle and
// queues every entry it expects to be accepted; a monitor compares the queue
// head against the outputs whenever out_valid is high and pops on drain.
// Works with PIPE_STAGE_SKID_EN defined or undefined.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 128;
    localparam int unsigned CW = 16;

    logic          clock;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW+CW-1:0] exp_q[$];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [CW-1:0] ctl(input logic [DW-1:0] d);
        return 16'hC000 | CW'(d);
    endfunction

    // One cycle: called at posedge+1, drives inputs, checks at negedge,
    // returns at the following posedge+1.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl,
                        input logic e_ir, input logic e_ov, input logic [1:0] e_occ);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(negedge clock);
        chk("in_ready", DW'(in_ready), DW'(e_ir));
        chk("out_valid", DW'(out_valid), DW'(e_ov));
        chk("occupancy", DW'(occupancy), DW'(e_occ));
        if (v && e_ir && !fl) exp_q.push_back({d, c});
        @(posedge clock);
        if (fl) exp_q.delete();
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (reset_n && !flush) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", out_data, '1);
                end else begin
                    chk("out_data", out_data, exp_q[0][CW +: DW]);
                    chk("out_ctrl", DW'(out_ctrl), DW'(exp_q[0][CW-1:0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("bubble_ctrl", DW'(out_ctrl), '0);
                chk("bubble_data", out_data, '0);
            end
        end
    end

    localparam logic [DW-1:0] VA = 128'hA;
    localparam logic [DW-1:0] VB = 128'hB;
    localparam logic [DW-1:0] VC = 128'hC;
    localparam logic [DW-1:0] VE = 128'hE;

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_ctrl", DW'(out_ctrl), '0);
        chk("rst_occupancy", DW'(occupancy), '0);
        chk("rst_in_ready", DW'(in_ready), '0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_before_edge", DW'(in_ready), '0);
        @(posedge clock); #1;
        chk("ready_after_edge", DW'(in_ready), DW'(1'b1));

        // Bubble: control forced to NOP while empty.
        step(1'b0, '0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);

        // Streaming 1..10 with no gaps.
        for (int i = 1; i <= 10; i++)
            step(1'b1, DW'(i), ctl(DW'(i)), 1'b1, 1'b0, 1'b1, (i > 1), (i > 1) ? 2'd1 : 2'd0);
        step(1'b0, '0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);

        // Backpressure.
        step(1'b1, VA, ctl(VA), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
`ifdef PIPE_STAGE_SKID_EN
        step(1'b1, VB, ctl(VB), 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        step(1'b1, VE, ctl(VE), 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
`else
        step(1'b1, VB, ctl(VB), 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        step(1'b1, VB, ctl(VB), 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        step(1'b1, VB, ctl(VB), 1'b1, 1'b0, 1'b1, 1'b1, 2'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
`endif

        // Flush with a held entry (FULL when the skid exists); 0xC must vanish.
        step(1'b1, VA, ctl(VA), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
`ifdef PIPE_STAGE_SKID_EN
        step(1'b1, VB, ctl(VB), 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
        step(1'b1, VC, ctl(VC), 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
`else
        step(1'b1, VC, ctl(VC), 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
`endif
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        // Flush while empty and ready: the offered entry is still discarded.
        step(1'b1, VC, ctl(VC), 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);

        // Asynchronous reset mid-cycle while BUSY.
        step(1'b1, VA, ctl(VA), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", DW'(out_valid), '0);
        chk("mid_rst_out_ctrl", DW'(out_ctrl), '0);
        chk("mid_rst_occupancy", DW'(occupancy), '0);
        chk("mid_rst_in_ready", DW'(in_ready), '0);
        exp_q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("mid_ready_before_edge", DW'(in_ready), '0);
        @(posedge clock); #1;
        chk("mid_ready_after_edge", DW'(in_ready), DW'(1'b1));

        // Traffic resumes cleanly after reset.
        step(1'b1, 128'h55, ctl(128'h55), 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);

        chk("queue_drained", DW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
